// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - clog2 constant function used to size the bit counter
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Number of bits needed to count 0..n-1 (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Start/busy/done handshake plus operand/result bus between a sequencer
// (master) and the serial subtractor (slave).
//   start      : request pulse from the sequencer
//   a, b       : minuend / subtrahend, W bits
//   busy       : subtractor is shifting bits
//   done       : one-cycle pulse, result valid
//   diff       : (a - b) mod 2^W
//   borrow_out : 1 iff a < b (unsigned)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int unsigned W = 4
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Combinational one-bit full subtractor: computes a - b - borrow_i.
//   a_i, b_i  : operand bits
//   borrow_i  : incoming borrow
//   diff_o    : difference bit
//   borrow_o  : outgoing borrow
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);
    logic a_xor_b;

    assign a_xor_b  = a_i ^ b_i;
    assign diff_o   = a_xor_b ^ borrow_i;
    // Borrow when b exceeds a, or when they are equal and a borrow is pending.
    assign borrow_o = (~a_i & b_i) | (~a_xor_b & borrow_i);
endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial W-bit subtractor, LSB first, one bit per clock. One full
// subtractor cell with a registered borrow; operands are shifted right and the
// difference bits enter the result register from the MSB side.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_subtractor_if.slave (start, a, b, busy, done, diff,
//          borrow_out)
// Throughput: W+2 cycles per operation (accept, W shift cycles, one DONE).
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_if.slave    bus
);
    localparam int unsigned CntW = (clog2(W) > 0) ? clog2(W) : 1;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_sr_q, a_sr_d;
    logic [W-1:0]    b_sr_q, b_sr_d;
    logic [W-1:0]    res_q, res_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            br_q, br_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bo_q, bo_d;

    logic            cell_diff;
    logic            cell_borrow;
    logic [W-1:0]    res_next;

    full_subtractor u_cell (
        .a_i      (a_sr_q[0]),
        .b_i      (b_sr_q[0]),
        .borrow_i (br_q),
        .diff_o   (cell_diff),
        .borrow_o (cell_borrow)
    );

    // New difference bit enters at the MSB; after W shifts the LSB lands at bit 0.
    assign res_next = W'({cell_diff, res_q} >> 1);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bo_d    = bo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_next;
                br_d   = cell_borrow;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(W - 1)) begin
                    diff_d  = res_next;
                    bo_d    = cell_borrow;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Illegal encoding recovers to idle.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    // Status decoded straight from registered state.
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a combinational full-subtractor cell with a registered borrow. It is the inverse-operation counterpart to the team's full-adder cell.
- Sits in the datapath lab as a low-area arithmetic unit. Controlled by a start/busy/done handshake from a sequencer.

Parameters:
- W, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  W  minuend; captured on the accept edge
- b  input  W  subtrahend; captured on the accept edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  W  result, (a - b) mod 2^W
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = IDLE; busy = 0; done = 0; diff = 0; borrow_out = 0.
  - Shift registers, bit counter and borrow register are all cleared.
  - The in-flight operation is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE, encoded 2'd0, 2'd1, 2'd2. The encoding 2'd3 is illegal and transitions to IDLE.
- IDLE:
  - On the edge where start = 1 (accept edge E0): a and b load into the shift registers, counter = 0, borrow = 0, next state SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: on each edge E1..EW:
  - The cell computes d = a_sr[0] ^ b_sr[0] ^ br and br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - d shifts into the result shift register from the MSB side; a_sr and b_sr shift right; br <= br_next; counter increments.
  - At EW (counter = W-1): diff <= completed result; borrow_out <= br_next; next state DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- busy = 1 exactly in SHIFT, i.e. the W cycles after E0. done = 1 exactly in DONE. Both are decoded from registered state (glitch-free).
- Latency: done is high during the cycle after edge EW. The next accept is possible at edge EW+2, so back-to-back throughput is W+2 cycles.
- start while busy or done: ignored. a and b changes after E0 have no effect.
- diff and borrow_out hold the last completed result until the next completion or reset. They do not show partial results while busy.
- Counter width is clog2(W). No other arithmetic wraps except diff, which is modulo 2^W by construction.

Decomposition:
- Package serial_sub_pkg:
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
  - A clog2 constant function for the counter width.
- Sub-module full_subtractor (combinational): inputs a, b, borrow_in; outputs diff, borrow_out. It is instantiated once for the bit-serial cell and is reusable for a ripple version.

Test Plan:
- W=4, a=5, b=3, start pulsed 1 cycle -> busy high 4 cycles; done pulse in 5th cycle after accept; diff=2, borrow_out=0.
- W=4, a=3, b=5 -> diff=14 (4'hE), borrow_out=1. Boundary pairs: a=0, b=0 -> 0/0; a=15, b=15 -> 0/0; a=0, b=15 -> 1/1.
- Exhaustive: all 256 (a,b) pairs for W=4, back-to-back starts every 6 cycles -> each diff = (a-b) mod 16, borrow_out = (a<b), exactly one done per request.
- start re-asserted with new a=9, b=1 during busy and during DONE -> ignored; the original result (e.g. 5-3=2) is still reported and only one done pulse occurs.
- rst asserted asynchronously 2 cycles into SHIFT -> busy, done, diff, borrow_out = 0 immediately. No done pulse follows. A new request 7-2 afterwards yields diff=5, borrow_out=0.
- Hold check: after 5-3 completes, 20 idle cycles with a and b toggling -> diff stays 2, borrow_out stays 0, done stays 0.
